// File: rtl/sram_req_arbiter_pkg.sv
// Shared types for the sram request arbiter: owner tags, FSM states and the
// owner-FIFO entry layout.
package sram_req_arbiter_pkg;

  // Which requester a memory transaction belongs to.
  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  // Arbiter FSM: IDLE picks a winner, ISSUE holds mem_req until accepted.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  // One outstanding transaction: who asked, and whether the answer is unwanted.
  typedef struct packed {
    owner_e owner;
    logic   discard;
  } arb_entry_t;

  localparam int ARB_ENTRY_WD = $bits(arb_entry_t);

endpackage

// File: rtl/sram_req_arbiter_if.sv
// sram-like request/response port. The master drives the request payload,
// the slave answers with addr_ok/data_ok and read data.
interface sram_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        wstrb;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter_owner_fifo.sv
// In-order FIFO of {owner, discard} tags, one per accepted-but-unanswered
// memory request. A flush marks every instruction entry as discarded.
module sram_req_arbiter_owner_fifo
  import sram_req_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  arb_entry_t       push_entry_i,
  input  logic             pop_i,
  input  logic             flush_inst_i,
  output arb_entry_t       head_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o,
  output logic             empty_o
);

  arb_entry_t       slot_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pop on empty is ignored; push is only refused when full and not popping.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign cnt_o   = cnt_q;
  assign head_o  = slot_q[rd_ptr_q];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Next pointers and occupancy; simultaneous push and pop leave cnt unchanged.
  always_comb begin
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  // Storage: flush tags instruction slots, a push in the same cycle overrides its slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_inst_i && slot_q[i].owner == OWNER_INST) slot_q[i].discard <= 1'b1;
      end
      if (do_push) slot_q[wr_ptr_q] <= push_entry_i;
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like memory port between the fetch port (read-only) and the
// data port. Data has fixed priority; responses are routed back in order via
// the owner FIFO, and flushed fetches have their responses swallowed.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_flush,
  sram_req_arbiter_if.slave  inst_s,
  sram_req_arbiter_if.slave  data_s,
  sram_req_arbiter_if.master mem_m
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  state_e            state_q;
  owner_e            owner_q;
  logic              discard_q;
  logic              mem_req_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wstrb_q;
  logic [DATA_W-1:0] wdata_q;

  arb_entry_t        head;
  arb_entry_t        push_entry;
  logic              push, pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              accept, flush_hit;

  // The fetch port never writes; its payload fields are intentionally ignored.
  logic unused_inst;
  assign unused_inst = &{1'b0, inst_s.wr, inst_s.size, inst_s.wstrb, inst_s.wdata};

  assign accept     = (state_q == ST_ISSUE) && mem_m.addr_ok && !reset;
  assign flush_hit  = inst_flush && (owner_q == OWNER_INST);
  assign push       = accept;
  assign push_entry = '{owner: owner_q, discard: discard_q | flush_hit};
  assign pop        = mem_m.data_ok && !fifo_empty && !reset;

  // Acceptance and response pulses go straight back to the owning requester.
  assign inst_s.addr_ok = accept && (owner_q == OWNER_INST) && !discard_q && !inst_flush;
  assign data_s.addr_ok = accept && (owner_q == OWNER_DATA);
  assign inst_s.data_ok = pop && (head.owner == OWNER_INST) && !head.discard && !inst_flush;
  assign data_s.data_ok = pop && (head.owner == OWNER_DATA);
  assign inst_s.rdata   = mem_m.rdata;
  assign data_s.rdata   = mem_m.rdata;

  assign mem_m.req   = mem_req_q;
  assign mem_m.wr    = wr_q;
  assign mem_m.size  = size_q;
  assign mem_m.addr  = addr_q;
  assign mem_m.wstrb = wstrb_q;
  assign mem_m.wdata = wdata_q;

  sram_req_arbiter_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_inst_i (inst_flush),
    .head_o       (head),
    .cnt_o        (fifo_cnt),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  // Arbiter FSM: grant in IDLE (data first), hold the registered request in ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWNER_INST;
      discard_q <= 1'b0;
      mem_req_q <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= '0;
      wstrb_q   <= 4'd0;
      wdata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_full) begin
            if (data_s.req) begin
              owner_q   <= OWNER_DATA;
              discard_q <= 1'b0;
              wr_q      <= data_s.wr;
              size_q    <= data_s.size;
              addr_q    <= data_s.addr;
              wstrb_q   <= data_s.wstrb;
              wdata_q   <= data_s.wdata;
              mem_req_q <= 1'b1;
              state_q   <= ST_ISSUE;
            end else if (inst_s.req && !inst_flush) begin
              owner_q   <= OWNER_INST;
              discard_q <= 1'b0;
              wr_q      <= 1'b0;
              size_q    <= 2'd2;
              addr_q    <= inst_s.addr;
              wstrb_q   <= 4'd0;
              wdata_q   <= '0;
              mem_req_q <= 1'b1;
              state_q   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // A latched fetch cannot be withdrawn, only marked as unwanted.
          if (flush_hit) discard_q <= 1'b1;
          if (mem_m.addr_ok) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Occupancy is only observed through fifo_full; keep the count visible for debug.
  logic unused_cnt;
  assign unused_cnt = &{1'b0, fifo_cnt};

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: drives inputs on the falling edge,
// samples 1 time unit later, and compares against hand-computed values.
module tb_sram_req_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic inst_flush;

  int checks_cnt = 0;
  int errors_cnt = 0;

  sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_bus ();
  sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_bus ();
  sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  sram_req_arbiter #(
    .MAX_OUTSTANDING (2),
    .ADDR_W          (32),
    .DATA_W          (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .inst_flush (inst_flush),
    .inst_s     (inst_bus.slave),
    .data_s     (data_bus.slave),
    .mem_m      (mem_bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] cnt_now;
  assign cnt_now = 32'(dut.u_fifo.cnt_o);

  initial begin
    reset          = 1'b1;
    inst_flush     = 1'b0;
    inst_bus.req   = 1'b0;
    inst_bus.wr    = 1'b0;
    inst_bus.size  = 2'd0;
    inst_bus.addr  = '0;
    inst_bus.wstrb = 4'd0;
    inst_bus.wdata = '0;
    data_bus.req   = 1'b0;
    data_bus.wr    = 1'b0;
    data_bus.size  = 2'd0;
    data_bus.addr  = '0;
    data_bus.wstrb = 4'd0;
    data_bus.wdata = '0;
    mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = 1'b0;
    mem_bus.rdata   = '0;

    // Reset state
    repeat (3) nxt();
    reset = 1'b0;
    settle();
    chk("rst mem_req",      32'(mem_bus.req), 0);
    chk("rst mem_addr",     mem_bus.addr, 0);
    chk("rst inst_addr_ok", 32'(inst_bus.addr_ok), 0);
    chk("rst data_addr_ok", 32'(data_bus.addr_ok), 0);
    chk("rst cnt",          cnt_now, 0);

    // 1: same-cycle requests, data wins
    nxt();
    data_bus.req = 1'b1; data_bus.wr = 1'b1; data_bus.size = 2'd2;
    data_bus.addr = 32'h1c000100; data_bus.wstrb = 4'hf; data_bus.wdata = 32'h12345678;
    inst_bus.req = 1'b1; inst_bus.addr = 32'h1c000000;
    settle();
    chk("t1 req latency", 32'(mem_bus.req), 0);
    nxt();
    mem_bus.addr_ok = 1'b1;
    settle();
    chk("t1 mem_req",      32'(mem_bus.req), 1);
    chk("t1 mem_addr",     mem_bus.addr, 32'h1c000100);
    chk("t1 mem_wr",       32'(mem_bus.wr), 1);
    chk("t1 mem_wstrb",    32'(mem_bus.wstrb), 32'hf);
    chk("t1 data_addr_ok", 32'(data_bus.addr_ok), 1);
    chk("t1 inst_addr_ok", 32'(inst_bus.addr_ok), 0);
    nxt();
    data_bus.req = 1'b0;
    mem_bus.addr_ok = 1'b0;
    settle();
    chk("t1 no b2b grant", 32'(mem_bus.req), 0);
    nxt();
    mem_bus.addr_ok = 1'b1;
    settle();
    chk("t1 inst mem_addr", mem_bus.addr, 32'h1c000000);
    chk("t1 inst mem_wr",   32'(mem_bus.wr), 0);
    chk("t1 inst mem_size", 32'(mem_bus.size), 2);
    chk("t1 inst wstrb",    32'(mem_bus.wstrb), 0);
    chk("t1 inst_addr_ok",  32'(inst_bus.addr_ok), 1);
    nxt();
    inst_bus.req = 1'b0;
    mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h0;
    settle();
    chk("t1 cnt two",        cnt_now, 2);
    chk("t1 data_data_ok",   32'(data_bus.data_ok), 1);
    chk("t1 inst_data_ok x", 32'(inst_bus.data_ok), 0);
    nxt();
    mem_bus.rdata = 32'haaaa0001;
    settle();
    chk("t1 inst_data_ok",   32'(inst_bus.data_ok), 1);
    chk("t1 inst_rdata",     inst_bus.rdata, 32'haaaa0001);
    chk("t1 data_data_ok x", 32'(data_bus.data_ok), 0);
    nxt();
    mem_bus.data_ok = 1'b0;
    settle();
    chk("t1 cnt drained", cnt_now, 0);

    // 2: three fetches, two outstanding allowed
    inst_bus.req = 1'b1; inst_bus.addr = 32'h1c000010;
    mem_bus.addr_ok = 1'b1;
    nxt();
    settle();
    chk("t2 a0 mem_addr", mem_bus.addr, 32'h1c000010);
    chk("t2 a0 addr_ok",  32'(inst_bus.addr_ok), 1);
    nxt();
    inst_bus.addr = 32'h1c000014;
    nxt();
    settle();
    chk("t2 a1 mem_addr", mem_bus.addr, 32'h1c000014);
    chk("t2 a1 addr_ok",  32'(inst_bus.addr_ok), 1);
    nxt();
    inst_bus.addr = 32'h1c000018;
    settle();
    chk("t2 full cnt",     cnt_now, 2);
    chk("t2 full no req",  32'(mem_bus.req), 0);
    nxt();
    mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h11110000;
    settle();
    chk("t2 still no req", 32'(mem_bus.req), 0);
    chk("t2 r0 data_ok",   32'(inst_bus.data_ok), 1);
    chk("t2 r0 rdata",     inst_bus.rdata, 32'h11110000);
    nxt();
    mem_bus.data_ok = 1'b0;
    settle();
    chk("t2 no req pop cyc", 32'(mem_bus.req), 0);
    nxt();
    settle();
    chk("t2 a2 mem_req",  32'(mem_bus.req), 1);
    chk("t2 a2 mem_addr", mem_bus.addr, 32'h1c000018);
    chk("t2 a2 addr_ok",  32'(inst_bus.addr_ok), 1);
    nxt();
    inst_bus.req = 1'b0;
    mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h22220000;
    settle();
    chk("t2 r1 rdata",   inst_bus.rdata, 32'h22220000);
    chk("t2 r1 data_ok", 32'(inst_bus.data_ok), 1);
    nxt();
    mem_bus.rdata = 32'h33330000;
    settle();
    chk("t2 r2 data_ok", 32'(inst_bus.data_ok), 1);
    nxt();
    mem_bus.data_ok = 1'b0;
    settle();
    chk("t2 cnt drained", cnt_now, 0);

    // 3: flushed fetch response is dropped
    inst_bus.req = 1'b1; inst_bus.addr = 32'h1c000000;
    mem_bus.addr_ok = 1'b1;
    nxt();
    settle();
    chk("t3 addr_ok", 32'(inst_bus.addr_ok), 1);
    nxt();
    inst_bus.req = 1'b0;
    mem_bus.addr_ok = 1'b0;
    inst_flush = 1'b1;
    nxt();
    inst_flush = 1'b0;
    mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h02800000;
    settle();
    chk("t3 inst_data_ok", 32'(inst_bus.data_ok), 0);
    chk("t3 data_data_ok", 32'(data_bus.data_ok), 0);
    nxt();
    mem_bus.data_ok = 1'b0;
    settle();
    chk("t3 cnt", cnt_now, 0);

    // 4: push and pop in the same cycle
    data_bus.req = 1'b1; data_bus.wr = 1'b0; data_bus.size = 2'd2;
    data_bus.addr = 32'h1c000200; data_bus.wstrb = 4'h0;
    mem_bus.addr_ok = 1'b1;
    nxt();
    settle();
    chk("t4 data_addr_ok", 32'(data_bus.addr_ok), 1);
    nxt();
    data_bus.req = 1'b0;
    inst_bus.req = 1'b1; inst_bus.addr = 32'h1c000300;
    nxt();
    mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h0000d0d0;
    settle();
    chk("t4 cnt before",     cnt_now, 1);
    chk("t4 data_data_ok",   32'(data_bus.data_ok), 1);
    chk("t4 inst_addr_ok",   32'(inst_bus.addr_ok), 1);
    chk("t4 inst_data_ok x", 32'(inst_bus.data_ok), 0);
    nxt();
    inst_bus.req = 1'b0;
    mem_bus.addr_ok = 1'b0;
    mem_bus.rdata = 32'h00001111;
    settle();
    chk("t4 cnt after",      cnt_now, 1);
    chk("t4 inst_data_ok",   32'(inst_bus.data_ok), 1);
    chk("t4 data_data_ok x", 32'(data_bus.data_ok), 0);
    nxt();
    mem_bus.data_ok = 1'b0;
    settle();
    chk("t4 cnt drained", cnt_now, 0);

    // 5: payload stable while mem_addr_ok is low
    data_bus.req = 1'b1; data_bus.wr = 1'b1; data_bus.size = 2'd1;
    data_bus.addr = 32'h1c000400; data_bus.wstrb = 4'h3; data_bus.wdata = 32'hcafef00d;
    nxt();
    data_bus.addr = 32'hffffffff; data_bus.wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("t5 hold%0d mem_req", i),  32'(mem_bus.req), 1);
      chk($sformatf("t5 hold%0d mem_addr", i), mem_bus.addr, 32'h1c000400);
      chk($sformatf("t5 hold%0d wdata", i),    mem_bus.wdata, 32'hcafef00d);
      chk($sformatf("t5 hold%0d addr_ok", i),  32'(data_bus.addr_ok), 0);
      nxt();
    end
    mem_bus.addr_ok = 1'b1;
    settle();
    chk("t5 addr_ok",  32'(data_bus.addr_ok), 1);
    chk("t5 mem_size", 32'(mem_bus.size), 1);
    nxt();
    data_bus.req = 1'b0;
    mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = 1'b1;
    settle();
    chk("t5 addr_ok once", 32'(data_bus.addr_ok), 0);
    chk("t5 data_data_ok", 32'(data_bus.data_ok), 1);
    nxt();
    mem_bus.data_ok = 1'b0;

    // 6: reset during ISSUE with one fetch outstanding
    inst_bus.req = 1'b1; inst_bus.addr = 32'h1c000500;
    mem_bus.addr_ok = 1'b1;
    nxt();
    settle();
    chk("t6 first addr_ok", 32'(inst_bus.addr_ok), 1);
    nxt();
    inst_bus.addr = 32'h1c000504;
    mem_bus.addr_ok = 1'b0;
    nxt();
    settle();
    chk("t6 issuing", 32'(mem_bus.req), 1);
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    inst_bus.req = 1'b0;
    mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'hdeadbeef;
    settle();
    chk("t6 mem_req dropped", 32'(mem_bus.req), 0);
    chk("t6 stray inst_ok",   32'(inst_bus.data_ok), 0);
    chk("t6 stray data_ok",   32'(data_bus.data_ok), 0);
    chk("t6 cnt",             cnt_now, 0);
    nxt();
    mem_bus.data_ok = 1'b0;
    settle();
    chk("t6 idle mem_req", 32'(mem_bus.req), 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
